md_sequencer: RTL
=================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Start  input  1  E-stage request to issue MDCtrl this cycle.
REQ-004 SHALL have port MDCtrl  input  3  op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
REQ-005 SHALL have port A  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
REQ-006 SHALL have port B  input  32  rt operand (divisor / multiplier).
REQ-007 SHALL have port Busy  output  1  operation in flight.
REQ-008 SHALL have port Stall  output  1  Busy | (Start & MDCtrl in 1..4), for hazard unit stalling any MD-class instruction in D.
REQ-009 SHALL have port HI  output  32  architectural HI register.
REQ-010 SHALL have port LO  output  32  architectural LO register.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV; Busy = (state != IDLE).
REQ-012 IDLE: Start & MDCtrl in {1,2} SHALL capture the 64-bit product into a pending register, load counter = 5, go MUL.
REQ-013 IDLE: Start & MDCtrl in {3,4} SHALL capture quotient/remainder into pending, load counter = 10, go DIV.
REQ-014 MUL/DIV: counter SHALL decrement each cycle; at counter == 1 SHALL write pending {HI,LO} and return to IDLE next edge; Busy therefore high exactly 5 (mult) or 10 (div) cycles after the issuing edge.
REQ-015 MULT/DIV SHALL be signed two's-complement, MULTU/DIVU unsigned; product HI = bits 63:32, LO = bits 31:0; div LO = quotient, HI = remainder, remainder sign follows dividend (truncating division).
REQ-016 Division by zero SHALL still run 10 cycles and SHALL leave HI/LO unchanged.
REQ-017 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO = 0x80000000, HI = 0 (no trap).
REQ-018 MTHI/MTLO with Start in IDLE SHALL write A to HI/LO at that edge, zero latency, Busy stays 0.
REQ-019 Any Start while Busy SHALL be ignored (hazard unit guarantees none); HI/LO and counter unaffected.
REQ-020 HI/LO outputs SHALL show old values until the completing edge; no partial results visible.
REQ-021 Operands SHALL be sampled only at the issuing edge; later A/B changes SHALL not affect the result.

Reset
REQ-022 reset low SHALL immediately force state IDLE, counter 0, pending 0, HI = 0, LO = 0, Busy = 0, Stall = Start-derived only.
REQ-023 Reset during MUL/DIV SHALL abort the operation with no HI/LO write after release.

Configuration
REQ-024 With MD_DIV_EN defined, DIV/DIVU SHALL behave per REQ-013..017.
REQ-025 Without MD_DIV_EN, MDCtrl 3/4 SHALL be treated as none: no state change, Busy/Stall not asserted, no divider logic synthesized.

Structure
REQ-026 MDCtrl encodings (mdNone..mdMTLO) and latency constants (MUL_CYCLES = 5, DIV_CYCLES = 10) SHALL live in shared define.v.
REQ-027 Arithmetic SHALL be a combinational sub-module md_alu (A, B, MDCtrl -> 64-bit result); md_sequencer holds FSM, counter, pending, HI/LO.

Verification
REQ-028 MULT A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO unchanged on cycles 1..4.
REQ-030 DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> 10 busy cycles, HI/LO unchanged.
REQ-031 MTHI A=0x12345678 in IDLE -> HI=0x12345678 next edge, Busy=0; second Start MULT issued while Busy -> ignored, result of first op only.
REQ-032 MULT issued, reset asserted at busy cycle 3 -> Busy=0, HI=LO=0 immediately and remain 0 after release.
REQ-033 Build without MD_DIV_EN, Start DIV -> Busy=0, Stall=0, HI/LO unchanged.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared MD-unit encodings and latency constants for md_sequencer and md_alu.
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        mdNone  = 3'd0,
        mdMULT  = 3'd1,
        mdMULTU = 3'd2,
        mdDIV   = 3'd3,
        mdDIVU  = 3'd4,
        mdMTHI  = 3'd5,
        mdMTLO  = 3'd6,
        mdRsvd  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    function automatic logic is_mul_op(input md_op_e op);
        return (op == mdMULT) || (op == mdMULTU);
    endfunction

endpackage

// File: rtl/md_sequencer_alu.sv
// Combinational multiply/divide datapath; divider only exists when MD_DIV_EN is defined.
module md_alu
    import md_sequencer_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [63:0] o_res
);

    logic signed [63:0] w_sa, w_sb, w_smul;
    logic        [63:0] w_umul;

    assign w_sa   = {{32{i_a[31]}}, i_a};
    assign w_sb   = {{32{i_b[31]}}, i_b};
    assign w_smul = w_sa * w_sb;
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

`ifdef MD_DIV_EN
    logic [31:0] w_sq, w_sr, w_uq, w_ur;

    // Zero divisor and the single signed overflow case are resolved here so the
    // native operators never see them.
    always_comb begin
        w_sq = '0;
        w_sr = '0;
        w_uq = '0;
        w_ur = '0;
        if (i_b != 32'd0) begin
            w_uq = i_a / i_b;
            w_ur = i_a % i_b;
            if (i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF) begin
                w_sq = 32'h8000_0000;
                w_sr = 32'd0;
            end else begin
                w_sq = $signed(i_a) / $signed(i_b);
                w_sr = $signed(i_a) % $signed(i_b);
            end
        end
    end
`endif

    always_comb begin
        o_res = '0;
        case (md_op_e'(i_op))
            mdMULT:  o_res = w_smul;
            mdMULTU: o_res = w_umul;
`ifdef MD_DIV_EN
            mdDIV:   o_res = {w_sr, w_sq};
            mdDIVU:  o_res = {w_ur, w_uq};
`endif
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MD sequencer: FSM, latency counter, pending result and HI/LO.
// Optional divider enabled by defining MD_DIV_EN.
module md_sequencer
    import md_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_pend;
    logic        r_pend_vld;
    logic [31:0] r_hi, r_lo;

    md_op_e      w_op;
    logic        w_is_mul, w_is_div;
    logic        w_issue, w_done;
    logic [63:0] w_res;

    assign w_op     = md_op_e'(MDCtrl);
    assign w_is_mul = is_mul_op(w_op);
`ifdef MD_DIV_EN
    assign w_is_div = (w_op == mdDIV) || (w_op == mdDIVU);
`else
    assign w_is_div = 1'b0;
`endif

    md_alu u_alu (
        .i_a   (A),
        .i_b   (B),
        .i_op  (MDCtrl),
        .o_res (w_res)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start && w_is_mul) begin
                    w_state_nxt = ST_MUL;
                    w_cnt_nxt   = MUL_CYCLES;
                    w_issue     = 1'b1;
                end else if (Start && w_is_div) begin
                    w_state_nxt = ST_DIV;
                    w_cnt_nxt   = DIV_CYCLES;
                    w_issue     = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_issue) begin
                r_pend     <= w_res;
                // A zero divisor still occupies the unit but must not retire.
                r_pend_vld <= !(w_is_div && (B == 32'd0));
            end
            if (w_done && r_pend_vld) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
            if (r_state == ST_IDLE && Start && w_op == mdMTHI) r_hi <= A;
            if (r_state == ST_IDLE && Start && w_op == mdMTLO) r_lo <= A;
        end
    end

    assign Busy  = (r_state != ST_IDLE);
    assign Stall = Busy | (Start & (w_is_mul | w_is_div));
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule
